// File: rtl/vtg_pkg.sv
// Shared types for the raster timing generator: axis phase enum,
// the shadowed timing/polarity record and the colour-bar geometry.
package vtg_pkg;

  // Phase order along one axis: front porch, sync, back porch, active.
  typedef enum logic [1:0] {
    PH_FP  = 2'd0,
    PH_SW  = 2'd1,
    PH_BP  = 2'd2,
    PH_ACT = 2'd3
  } vtg_phase_e;

  // Storage width of each shadowed timing field; H_WIDTH and V_WIDTH
  // must not exceed this.
  localparam int VTG_FIELD_W = 16;

  // Colour bars are 2**VTG_BAR_SHIFT pixels wide.
  localparam int VTG_BAR_SHIFT = 3;

  // Timing and polarity settings captured at frame boundaries.
  typedef struct packed {
    logic [VTG_FIELD_W-1:0] hfp;
    logic [VTG_FIELD_W-1:0] hsw;
    logic [VTG_FIELD_W-1:0] hbp;
    logic [VTG_FIELD_W-1:0] hact;
    logic [VTG_FIELD_W-1:0] vfp;
    logic [VTG_FIELD_W-1:0] vsw;
    logic [VTG_FIELD_W-1:0] vbp;
    logic [VTG_FIELD_W-1:0] vact;
    logic                   hpol;
    logic                   vpol;
    logic                   pat;
  } vtg_cfg_t;

endpackage

// File: rtl/vtg_if.sv
// Pixel-side bundle of the timing generator: upstream request/data
// handshake plus the registered video output signals.
interface vtg_if #(
  parameter int H_WIDTH    = 12,
  parameter int V_WIDTH    = 12,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3
);
  logic                           req_o;
  logic [CHANNELS*DATA_WIDTH-1:0] data_i;
  logic [CHANNELS*DATA_WIDTH-1:0] data_o;
  logic                           hsync_o;
  logic                           vsync_o;
  logic                           de_o;
  logic [H_WIDTH-1:0]             x_o;
  logic [V_WIDTH-1:0]             y_o;
  logic                           sof_o;
  logic                           eol_o;

  modport master (
    output req_o, data_o, hsync_o, vsync_o, de_o, x_o, y_o, sof_o, eol_o,
    input  data_i
  );

  modport slave (
    input  req_o, data_o, hsync_o, vsync_o, de_o, x_o, y_o, sof_o, eol_o,
    output data_i
  );
endinterface

// File: rtl/vtg_axis_cnt.sv
// One raster axis: wrapping counter, phase decode from cumulative end
// points, zero-total clamp and active-area coordinate.
module vtg_axis_cnt
  import vtg_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic [W-1:0] fp_i,
  input  logic [W-1:0] sw_i,
  input  logic [W-1:0] bp_i,
  input  logic [W-1:0] act_i,
  output vtg_phase_e   phase_o,
  output logic         last_o,
  output logic [W-1:0] coord_o
);
  // Two extra bits hold the sum of four W-bit fields without overflow.
  localparam int TW = W + 2;

  logic [TW-1:0] w_end_fp;
  logic [TW-1:0] w_end_sw;
  logic [TW-1:0] w_end_bp;
  logic [TW-1:0] w_tot_raw;
  logic [TW-1:0] w_tot;
  logic [TW-1:0] w_last_cnt;
  logic [TW-1:0] r_cnt;

  assign w_end_fp  = TW'(fp_i);
  assign w_end_sw  = w_end_fp + TW'(sw_i);
  assign w_end_bp  = w_end_sw + TW'(bp_i);
  assign w_tot_raw = w_end_bp + TW'(act_i);
  // An all-zero axis still needs one count per period.
  assign w_tot      = (w_tot_raw == '0) ? TW'(1) : w_tot_raw;
  assign w_last_cnt = w_tot - TW'(1);
  // ">=" also recovers if the count is ever beyond the current total.
  assign last_o     = (r_cnt >= w_last_cnt);

  // Counter: held at 0 while cleared, wraps after the last position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (adv_i) begin
      r_cnt <= last_o ? '0 : r_cnt + TW'(1);
    end
  end

  // Phase decode; an axis with zero active length never reports ACT.
  always_comb begin
    phase_o = PH_FP;
    coord_o = '0;
    if (r_cnt < w_end_fp) begin
      phase_o = PH_FP;
    end else if (r_cnt < w_end_sw) begin
      phase_o = PH_SW;
    end else if ((r_cnt < w_end_bp) || (act_i == '0)) begin
      phase_o = PH_BP;
    end else begin
      phase_o = PH_ACT;
      coord_o = W'(r_cnt - w_end_bp);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with pixel pass-through. Timing inputs are
// shadowed and take effect only at frame boundaries (or while idle).
// Optional feature macro: VTG_PATTERN_EN adds pattern_en_i, which
// replaces the upstream pixel with 8-pixel colour bars.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_WIDTH    = 12,
  parameter int V_WIDTH    = 12,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               hpol_i,
  input  logic               vpol_i,
  input  logic [H_WIDTH-1:0] hfp_i,
  input  logic [H_WIDTH-1:0] hsw_i,
  input  logic [H_WIDTH-1:0] hbp_i,
  input  logic [H_WIDTH-1:0] hactive_i,
  input  logic [V_WIDTH-1:0] vfp_i,
  input  logic [V_WIDTH-1:0] vsw_i,
  input  logic [V_WIDTH-1:0] vbp_i,
  input  logic [V_WIDTH-1:0] vactive_i,
`ifdef VTG_PATTERN_EN
  input  logic               pattern_en_i,
`endif
  vtg_if.master              vid
);
  localparam int PW = CHANNELS * DATA_WIDTH;

  vtg_cfg_t           w_cfg_in;
  vtg_cfg_t           r_cfg;
  logic               w_cfg_unused;
  vtg_phase_e         w_h_ph;
  vtg_phase_e         w_v_ph;
  logic               w_h_last;
  logic               w_v_last;
  logic [H_WIDTH-1:0] w_hx;
  logic [V_WIDTH-1:0] w_vy;
  logic               w_act;
  logic               w_req;
  logic               w_load;
  logic [PW-1:0]      w_data_next;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic [H_WIDTH-1:0] r_x;
  logic [V_WIDTH-1:0] r_y;
  logic               r_sof;
  logic               r_eol;
  logic [PW-1:0]      r_data;

  // Pack the live timing inputs into the shadow record layout.
  always_comb begin
    w_cfg_in      = '0;
    w_cfg_in.hfp  = VTG_FIELD_W'(hfp_i);
    w_cfg_in.hsw  = VTG_FIELD_W'(hsw_i);
    w_cfg_in.hbp  = VTG_FIELD_W'(hbp_i);
    w_cfg_in.hact = VTG_FIELD_W'(hactive_i);
    w_cfg_in.vfp  = VTG_FIELD_W'(vfp_i);
    w_cfg_in.vsw  = VTG_FIELD_W'(vsw_i);
    w_cfg_in.vbp  = VTG_FIELD_W'(vbp_i);
    w_cfg_in.vact = VTG_FIELD_W'(vactive_i);
    w_cfg_in.hpol = hpol_i;
    w_cfg_in.vpol = vpol_i;
`ifdef VTG_PATTERN_EN
    w_cfg_in.pat  = pattern_en_i;
`else
    w_cfg_in.pat  = 1'b0;
`endif
  end

  // Upper field bits beyond the configured widths are not consumed.
  assign w_cfg_unused = ^r_cfg;

  // Reload while idle and on the final clock of every frame.
  assign w_load = ~en_i | (w_h_last & w_v_last);

  // Shadow register for timing, polarity and pattern select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg <= '0;
    end else if (w_load) begin
      r_cfg <= w_cfg_in;
    end
  end

  vtg_axis_cnt #(.W(H_WIDTH)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~en_i),
    .adv_i   (1'b1),
    .fp_i    (r_cfg.hfp[H_WIDTH-1:0]),
    .sw_i    (r_cfg.hsw[H_WIDTH-1:0]),
    .bp_i    (r_cfg.hbp[H_WIDTH-1:0]),
    .act_i   (r_cfg.hact[H_WIDTH-1:0]),
    .phase_o (w_h_ph),
    .last_o  (w_h_last),
    .coord_o (w_hx)
  );

  vtg_axis_cnt #(.W(V_WIDTH)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~en_i),
    .adv_i   (w_h_last),
    .fp_i    (r_cfg.vfp[V_WIDTH-1:0]),
    .sw_i    (r_cfg.vsw[V_WIDTH-1:0]),
    .bp_i    (r_cfg.vbp[V_WIDTH-1:0]),
    .act_i   (r_cfg.vact[V_WIDTH-1:0]),
    .phase_o (w_v_ph),
    .last_o  (w_v_last),
    .coord_o (w_vy)
  );

  assign w_act = (w_h_ph == PH_ACT) && (w_v_ph == PH_ACT);
  // The request comes straight from the counters, so it leads the
  // registered data enable by one clock.
  assign w_req = en_i & w_act & ~r_cfg.pat;

`ifdef VTG_PATTERN_EN
  logic [2:0]    w_bar;
  logic [PW-1:0] w_bars;

  assign w_bar = w_hx[VTG_BAR_SHIFT +: 3];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_bar
      assign w_bars[gi*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{w_bar[gi % 3]}};
    end
  endgenerate

  assign w_data_next = r_cfg.pat ? (w_act ? w_bars : '0)
                                 : (w_req ? vid.data_i : '0);
`else
  assign w_data_next = w_req ? vid.data_i : '0;
`endif

  // Output stage, one clock behind the counter state; idle while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_data  <= '0;
    end else if (!en_i) begin
      r_hsync <= ~hpol_i;
      r_vsync <= ~vpol_i;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_hsync <= (w_h_ph == PH_SW) ? r_cfg.hpol : ~r_cfg.hpol;
      r_vsync <= (w_v_ph == PH_SW) ? r_cfg.vpol : ~r_cfg.vpol;
      r_de    <= w_act;
      r_x     <= w_act ? w_hx : '0;
      r_y     <= w_act ? w_vy : '0;
      r_sof   <= w_act && (w_hx == '0) && (w_vy == '0);
      r_eol   <= w_act && w_h_last;
      r_data  <= w_data_next;
    end
  end

  assign vid.req_o   = w_req;
  assign vid.hsync_o = r_hsync;
  assign vid.vsync_o = r_vsync;
  assign vid.de_o    = r_de;
  assign vid.x_o     = r_x;
  assign vid.y_o     = r_y;
  assign vid.sof_o   = r_sof;
  assign vid.eol_o   = r_eol;
  assign vid.data_o  = r_data;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 10x7 raster: table of
// per-cycle expectations plus hand-written reset/enable/config sequences.
module tb_video_timing_gen;
  localparam int HW = 12;
  localparam int VW = 12;
  localparam int DW = 8;
  localparam int CH = 3;

  // Observation bundle: {req,hs,vs,de,sof,eol,x[12],y[12],data[24]}
  localparam logic [53:0] M_ALL    = '1;
  localparam logic [53:0] M_SYNC   = {6'b011100, 48'h0};
  localparam logic [53:0] M_NODATA = {6'b011111, 24'hFFFFFF, 24'h0};
  localparam int B_REQ = 53;
  localparam int B_HS  = 52;
  localparam int B_VS  = 51;
  localparam int B_DE  = 50;
  localparam int B_SOF = 49;
  localparam int B_EOL = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic          hpol_i;
  logic          vpol_i;
  logic [HW-1:0] hfp_i, hsw_i, hbp_i, hactive_i;
  logic [VW-1:0] vfp_i, vsw_i, vbp_i, vactive_i;

  vtg_if #(.H_WIDTH(HW), .V_WIDTH(VW), .DATA_WIDTH(DW), .CHANNELS(CH)) vid ();

  video_timing_gen #(.H_WIDTH(HW), .V_WIDTH(VW), .DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .hpol_i       (hpol_i),
    .vpol_i       (vpol_i),
    .hfp_i        (hfp_i),
    .hsw_i        (hsw_i),
    .hbp_i        (hbp_i),
    .hactive_i    (hactive_i),
    .vfp_i        (vfp_i),
    .vsw_i        (vsw_i),
    .vbp_i        (vbp_i),
    .vactive_i    (vactive_i),
`ifdef VTG_PATTERN_EN
    .pattern_en_i (1'b0),
`endif
    .vid          (vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [53:0] mask;
    logic [53:0] exp;
  } vec_t;

  vec_t        vt[$];
  logic [53:0] log_q [0:255];
  int          n_chk = 0;
  int          n_err = 0;
  int          src_x = 0;
  int          src_y = 0;
  int          src_w = 4;
  int          src_h = 3;

  // Upstream frame source: answers each request with x+16y, raster order.
  always @(negedge clk) begin
    if (rst || !en_i) begin
      src_x = 0;
      src_y = 0;
      vid.data_i = '0;
    end else if (vid.req_o) begin
      vid.data_i = 24'(src_x + 16 * src_y);
      src_x++;
      if (src_x == src_w) begin
        src_x = 0;
        src_y = (src_y + 1 == src_h) ? 0 : src_y + 1;
      end
    end else begin
      vid.data_i = '0;
    end
  end

  function automatic logic [53:0] obs();
    return {vid.req_o, vid.hsync_o, vid.vsync_o, vid.de_o, vid.sof_o, vid.eol_o,
            vid.x_o, vid.y_o, vid.data_o};
  endfunction

  function automatic logic [53:0] pk(logic req, logic hs, logic vs, logic de,
                                     logic sof, logic eol, int x, int y, int d);
    return {req, hs, vs, de, sof, eol, 12'(x), 12'(y), 24'(d)};
  endfunction

  task automatic add(input int k, input logic [53:0] m, input logic [53:0] e);
    vec_t v;
    v.k = k; v.mask = m; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [53:0] a, input logic [53:0] e,
                     input logic [53:0] m);
    n_chk++;
    if ((a & m) !== (e & m)) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a & m, e & m);
    end else begin
      $display("ok   %s: %h", nm, a & m);
    end
  endtask

  task automatic chk_i(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end else begin
      $display("ok   %s: %0d", nm, a);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Enable timing and log outputs; log_q[k] reflects counter state k.
  task automatic run(input int ncyc, input int chg_k);
    en_i = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      log_q[k] = obs();
      if (k == chg_k) hactive_i = 12'd6;
    end
  endtask

  task automatic check_vecs(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      chk($sformatf("%s k=%0d", tag, vt[i].k), log_q[vt[i].k], vt[i].exp, vt[i].mask);
  endtask

  function automatic int count_bit(input int b, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (log_q[k][b]) n++;
    return n;
  endfunction

  function automatic int nth_rise(input int b, input int nth, input int hi);
    int seen = 0;
    for (int k = 1; k <= hi; k++)
      if (log_q[k][b] && !log_q[k-1][b]) begin
        seen++;
        if (seen == nth) return k;
      end
    return -1;
  endfunction

  int s_p0, s_mn, s_of, s_rs, s_hc, s_end;
  int r1, r2;

  initial begin
    rst = 1'b1; en_i = 1'b0; hpol_i = 1'b0; vpol_i = 1'b0;
    hfp_i = 12'd2; hsw_i = 12'd3; hbp_i = 12'd1; hactive_i = 12'd4;
    vfp_i = 12'd1; vsw_i = 12'd2; vbp_i = 12'd1; vactive_i = 12'd3;

    // Active-low syncs: idle high, low in SW phase.
    s_p0 = vt.size();
    add(0,  M_SYNC, pk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(2,  M_SYNC, pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(5,  M_SYNC, pk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(10, M_SYNC, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(12, M_SYNC, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Main frame, active-high syncs, data = x + 16y.
    s_mn = vt.size();
    add(0,   M_ALL, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(2,   M_ALL, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(4,   M_ALL, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(5,   M_ALL, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(10,  M_ALL, pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(12,  M_ALL, pk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(29,  M_ALL, pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(30,  M_ALL, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(45,  M_ALL, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(46,  M_ALL, pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    add(47,  M_ALL, pk(1, 0, 0, 1, 0, 0, 1, 0, 1));
    add(49,  M_ALL, pk(0, 0, 0, 1, 0, 1, 3, 0, 3));
    add(50,  M_ALL, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(57,  M_ALL, pk(1, 0, 0, 1, 0, 0, 1, 1, 17));
    add(69,  M_ALL, pk(0, 0, 0, 1, 0, 1, 3, 2, 35));
    add(70,  M_ALL, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(116, M_ALL, pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    add(119, M_ALL, pk(0, 0, 0, 1, 0, 1, 3, 0, 3));
    // Run that is cut off mid-line.
    s_of = vt.size();
    add(46,  M_ALL, pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    add(47,  M_ALL, pk(1, 0, 0, 1, 0, 0, 1, 0, 1));
    // Restart after the cut: begins again at h=0, v=0.
    s_rs = vt.size();
    add(0,   M_ALL, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(2,   M_ALL, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(46,  M_ALL, pk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    add(47,  M_ALL, pk(1, 0, 0, 1, 0, 0, 1, 0, 1));
    // hactive 4 -> 6 at k=35: frame 0 keeps htot=10, frame 1 uses 12.
    s_hc = vt.size();
    add(49,  M_NODATA, pk(0, 0, 0, 1, 0, 1, 3, 0, 0));
    add(59,  M_NODATA, pk(0, 0, 0, 1, 0, 1, 3, 1, 0));
    add(76,  M_NODATA, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(116, M_NODATA, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(124, M_NODATA, pk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(129, M_NODATA, pk(0, 0, 0, 1, 0, 1, 5, 0, 0));
    add(131, M_NODATA, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(208, M_NODATA, pk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    s_end = vt.size();

    #12;
    chk("reset_all_zero", obs(), '0, M_ALL);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("idle_pol0", obs(), pk(0, 1, 1, 0, 0, 0, 0, 0, 0), M_ALL);

    run(13, -1);
    check_vecs("pol0", s_p0, s_mn);
    en_i = 1'b0;
    cyc(1);
    chk("off_idle_pol0", obs(), pk(0, 1, 1, 0, 0, 0, 0, 0, 0), M_ALL);

    hpol_i = 1'b1; vpol_i = 1'b1;
    cyc(2);
    chk("idle_pol1", obs(), '0, M_ALL);

    run(140, -1);
    check_vecs("main", s_mn, s_of);
    chk_i("main_hsync_cycles", count_bit(B_HS, 0, 69), 21);
    chk_i("main_vsync_cycles", count_bit(B_VS, 0, 69), 20);
    chk_i("main_de_cycles",    count_bit(B_DE, 0, 69), 12);
    chk_i("main_req_cycles",   count_bit(B_REQ, 0, 69), 12);
    chk_i("main_eol_count",    count_bit(B_EOL, 0, 69), 3);
    chk_i("main_sof_count",    count_bit(B_SOF, 0, 69), 1);
    r1 = nth_rise(B_SOF, 1, 139);
    r2 = nth_rise(B_SOF, 2, 139);
    chk_i("main_frame_period", r2 - r1, 70);

    en_i = 1'b0;
    cyc(3);
    run(48, -1);
    check_vecs("cut", s_of, s_rs);
    en_i = 1'b0;
    cyc(1);
    chk("en_off_idle", obs(), '0, M_ALL);
    cyc(2);
    run(48, -1);
    check_vecs("restart", s_rs, s_hc);

    // Asynchronous reset in the middle of an active line.
    #2;
    rst = 1'b1;
    en_i = 1'b0;
    #1;
    chk("async_rst", obs(), '0, M_ALL);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    hactive_i = 12'd0;
    cyc(2);
    run(100, -1);
    chk_i("hact0_de_cycles",  count_bit(B_DE, 0, 99), 0);
    chk_i("hact0_req_cycles", count_bit(B_REQ, 0, 99), 0);
    r1 = nth_rise(B_VS, 1, 99);
    r2 = nth_rise(B_VS, 2, 99);
    chk_i("hact0_vs_first",  r1, 6);
    chk_i("hact0_vs_period", r2 - r1, 42);
    chk_i("hact0_hs_cycles", count_bit(B_HS, 0, 41), 21);

    en_i = 1'b0;
    hactive_i = 12'd4;
    cyc(2);
    run(220, 35);
    check_vecs("hchg", s_hc, s_end);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
